// File: rtl/shm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shm_pkg                                                    |
// | Brief   : IS31FL3731 / Scroll Hat Mini constants, types and helpers  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package shm_pkg;

  // IS31FL3731 register map
  localparam logic [7:0] c_cmd_reg       = 8'hFD;
  localparam logic [7:0] c_page_frame0   = 8'h00;
  localparam logic [7:0] c_page_function = 8'h0B;
  localparam logic [7:0] c_shutdown_reg  = 8'h0A;
  localparam logic [7:0] c_pwm_offset    = 8'h24;

  // Scroll Hat Mini geometry
  localparam int NUM_COLS = 17;
  localparam int NUM_ROWS = 7;
  localparam int NUM_LEDS = NUM_COLS * NUM_ROWS;
  localparam int IDX_W    = 7;

  typedef logic [IDX_W-1:0] pix_idx_t;
  typedef logic [2:0]       shm_state_t;

  localparam shm_state_t S_IDLE   = 3'd0;
  localparam shm_state_t S_SCAN   = 3'd1;
  localparam shm_state_t S_EXTEND = 3'd2;
  localparam shm_state_t S_SEND   = 3'd3;
  localparam shm_state_t S_AWAIT  = 3'd4;

  // One I2C_CONTROLLER request; rpt is wide enough for any REPEAT_SZ <= 8
  typedef struct packed {
    logic [7:0] location;
    logic [7:0] data;
    logic [7:0] rpt;
  } shm_req_t;

  // PWM register address: each column owns 8 registers, row 7 unused
  function automatic logic [7:0] xy_to_addr(input logic [4:0] x, input logic [2:0] y);
    return c_pwm_offset + {x, 3'b000} + {5'b00000, y};
  endfunction

  function automatic pix_idx_t xy_to_idx(input logic [4:0] x, input logic [2:0] y);
    return pix_idx_t'(int'(x) * NUM_ROWS + int'(y));
  endfunction

  function automatic logic [4:0] idx_to_col(input pix_idx_t idx);
    return 5'(int'(idx) / NUM_ROWS);
  endfunction

  function automatic logic [2:0] idx_to_row(input pix_idx_t idx);
    return 3'(int'(idx) % NUM_ROWS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shm_pixel_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shm_pixel_store                                            |
// | Brief   : 119 x 8-bit framebuffer with per-pixel dirty bits          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module shm_pixel_store
  import shm_pkg::*;
#(
  parameter int RUN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  pix_idx_t         i_wr_idx,
  input  logic [7:0]       i_wr_value,
  input  logic             i_set_all,
  input  logic             i_set_run,
  input  logic             i_clr_run,
  input  pix_idx_t         i_run_start,
  input  logic [RUN_W-1:0] i_run_len,
  input  logic [7:0]       i_run_value,
  input  pix_idx_t         i_rd_idx,
  output logic [7:0]       o_rd_value,
  output logic             o_rd_dirty,
  input  pix_idx_t         i_nx_idx,
  output logic [7:0]       o_nx_value,
  output logic             o_nx_dirty,
  output logic             o_any_dirty
);

  logic [7:0]          r_mem [NUM_LEDS];
  logic [NUM_LEDS-1:0] r_dirty;
  logic [NUM_LEDS-1:0] w_wr_hit;
  logic [NUM_LEDS-1:0] w_in_run;
  logic [NUM_LEDS-1:0] w_dirty_nxt;
  logic [31:0]         w_run_end;

  assign w_run_end = 32'(i_run_start) + 32'(i_run_len);

  // A run clear only drops pixels still holding the value being sent, so a
  // rewrite between latching and issuing the run is never lost.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
    assign w_wr_hit[gi]    = i_wr_en && (i_wr_idx == pix_idx_t'(gi));
    assign w_in_run[gi]    = (32'(gi) >= 32'(i_run_start)) && (32'(gi) < w_run_end);
    assign w_dirty_nxt[gi] = w_wr_hit[gi] | i_set_all | (i_set_run & w_in_run[gi]) |
                             (r_dirty[gi] & ~(i_clr_run & w_in_run[gi] &
                                              (r_mem[gi] == i_run_value)));
  end

  // Pixel values and dirty flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) r_mem[i] <= 8'h00;
      r_dirty <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_wr_hit[i]) r_mem[i] <= i_wr_value;
      end
      r_dirty <= w_dirty_nxt;
    end
  end

  assign o_rd_value  = (int'(i_rd_idx) < NUM_LEDS) ? r_mem[i_rd_idx]   : 8'h00;
  assign o_rd_dirty  = (int'(i_rd_idx) < NUM_LEDS) ? r_dirty[i_rd_idx] : 1'b0;
  assign o_nx_value  = (int'(i_nx_idx) < NUM_LEDS) ? r_mem[i_nx_idx]   : 8'h00;
  assign o_nx_dirty  = (int'(i_nx_idx) < NUM_LEDS) ? r_dirty[i_nx_idx] : 1'b0;
  assign o_any_dirty = |r_dirty;

endmodule
`default_nettype wire

// File: rtl/shm_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shm_frame_writer                                           |
// | Brief   : Sends changed Scroll Hat Mini pixels as PWM burst writes   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module shm_frame_writer
  import shm_pkg::*;
#(
  parameter int REPEAT_SZ = 6,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 wr_en,
  input  logic [4:0]           wr_x,
  input  logic [2:0]           wr_y,
  input  logic [7:0]           wr_value,
  input  logic                 refresh_all,
  output logic                 activate,
  output logic [7:0]           location,
  output logic [7:0]           data,
  output logic [REPEAT_SZ-1:0] data_repeat,
  input  logic                 busy,
  input  logic                 abort,
  output logic                 idle,
  output logic                 frame_done,
  output logic [7:0]           err_count
);

  localparam int RUN_W   = REPEAT_SZ + 1;
  localparam int RUN_MAX = 1 << REPEAT_SZ;
  localparam int ATT_W   = $clog2(MAX_RETRY + 1);

  shm_state_t       r_state, w_state_nxt;
  pix_idx_t         r_ptr, r_lap, r_start;
  logic [2:0]       r_start_row;
  logic [7:0]       r_value, r_loc;
  logic [RUN_W-1:0] r_run;
  logic [ATT_W-1:0] r_attempt;
  logic             r_busy_seen, r_abort_seen, r_activate, r_frame_done;
  logic [7:0]       r_err_count;
  shm_req_t         r_req;

  logic       w_wr_valid, w_rd_dirty, w_nx_dirty, w_any_dirty, w_same_col;
  logic       w_extend, w_issue, w_burst_done, w_aborted, w_can_retry;
  logic       w_retry, w_drop, w_ok, w_idle;
  logic [7:0] w_rd_value, w_nx_value;
  pix_idx_t   w_wr_idx, w_nx_idx, w_ptr_inc, w_ptr_adv;
  logic [8:0] w_adv_sum;

  assign w_wr_valid = wr_en && (int'(wr_x) < NUM_COLS) && (int'(wr_y) < NUM_ROWS);
  assign w_wr_idx   = xy_to_idx(wr_x, wr_y);
  assign w_nx_idx   = pix_idx_t'(int'(r_start) + int'(r_run));
  assign w_same_col = (int'(r_start_row) + int'(r_run)) < NUM_ROWS;
  assign w_ptr_inc  = (int'(r_ptr) == NUM_LEDS - 1) ? '0 : r_ptr + 1'b1;
  // Resume scanning right after the run just sent (start + run)
  assign w_adv_sum  = 9'(r_start) + 9'(r_req.rpt) + 9'd1;
  assign w_ptr_adv  = (w_adv_sum >= 9'(NUM_LEDS)) ? 7'(w_adv_sum - 9'(NUM_LEDS))
                                                   : 7'(w_adv_sum);

  shm_pixel_store #(.RUN_W(RUN_W)) u_store (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (w_wr_valid),
    .i_wr_idx    (w_wr_idx),
    .i_wr_value  (wr_value),
    .i_set_all   (refresh_all),
    .i_set_run   (w_retry),
    .i_clr_run   (w_issue),
    .i_run_start (r_start),
    .i_run_len   (r_run),
    .i_run_value (r_value),
    .i_rd_idx    (r_ptr),
    .o_rd_value  (w_rd_value),
    .o_rd_dirty  (w_rd_dirty),
    .i_nx_idx    (w_nx_idx),
    .o_nx_value  (w_nx_value),
    .o_nx_dirty  (w_nx_dirty),
    .o_any_dirty (w_any_dirty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable && w_any_dirty) w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (!enable)                             w_state_nxt = S_IDLE;
        else if (w_rd_dirty)                     w_state_nxt = S_EXTEND;
        else if (int'(r_lap) == NUM_LEDS - 1)    w_state_nxt = S_IDLE;
      end
      S_EXTEND: if (!w_extend) w_state_nxt = S_SEND;
      S_SEND:   if (!busy)     w_state_nxt = S_AWAIT;
      S_AWAIT:  if (w_burst_done) w_state_nxt = w_retry ? S_SEND : S_SCAN;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state strobes driving the datapath and the pixel store
  always_comb begin
    w_extend     = (r_state == S_EXTEND) && w_same_col && w_nx_dirty &&
                   (w_nx_value == r_value) && (int'(r_run) < RUN_MAX);
    w_issue      = (r_state == S_SEND) && !busy;
    w_burst_done = (r_state == S_AWAIT) && r_busy_seen && !busy;
    w_aborted    = r_abort_seen || abort;
    w_can_retry  = int'(r_attempt) < MAX_RETRY;
    w_retry      = w_burst_done && w_aborted && w_can_retry;
    w_drop       = w_burst_done && w_aborted && !w_can_retry;
    w_ok         = w_burst_done && !w_aborted;
    w_idle       = (r_state == S_IDLE) && !w_any_dirty;
  end

  // Scan pointer, run tracking and the request handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_lap        <= '0;
      r_start      <= '0;
      r_start_row  <= '0;
      r_value      <= '0;
      r_loc        <= '0;
      r_run        <= '0;
      r_attempt    <= '0;
      r_busy_seen  <= 1'b0;
      r_abort_seen <= 1'b0;
      r_activate   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_count  <= '0;
      r_req        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: r_lap <= '0;
        S_SCAN: begin
          if (enable) begin
            if (w_rd_dirty) begin
              r_start     <= r_ptr;
              r_start_row <= idx_to_row(r_ptr);
              r_value     <= w_rd_value;
              r_loc       <= xy_to_addr(idx_to_col(r_ptr), idx_to_row(r_ptr));
              r_run       <= RUN_W'(1);
              r_attempt   <= ATT_W'(1);
            end else begin
              r_ptr <= w_ptr_inc;
              r_lap <= r_lap + 1'b1;
            end
          end
        end
        S_EXTEND: if (w_extend) r_run <= r_run + 1'b1;
        S_SEND: begin
          if (!busy) begin
            r_activate   <= 1'b1;
            r_req        <= '{location: r_loc, data: r_value, rpt: 8'(r_run) - 8'd1};
            r_busy_seen  <= 1'b0;
            r_abort_seen <= 1'b0;
          end
        end
        S_AWAIT: begin
          if (busy && !r_busy_seen) begin
            r_busy_seen <= 1'b1;
            r_activate  <= 1'b0;
          end
          if (abort) r_abort_seen <= 1'b1;
          if (w_retry) r_attempt <= r_attempt + 1'b1;
          if (w_ok || w_drop) begin
            r_ptr <= w_ptr_adv;
            r_lap <= '0;
          end
          if (w_drop && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
          // A write landing this cycle means the frame is not finished yet
          if (w_ok && !w_any_dirty && !w_wr_valid && !refresh_all) r_frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign activate    = r_activate;
  assign location    = r_req.location;
  assign data        = r_req.data;
  assign data_repeat = r_req.rpt[REPEAT_SZ-1:0];
  assign idle        = w_idle;
  assign frame_done  = r_frame_done;
  assign err_count   = r_err_count;

endmodule
`default_nettype wire
